// File: rtl/amba_axi_pkg.sv
// Minimal AXI4 single-beat channel bundles shared by the interconnect-facing peripherals.
package amba_axi_pkg;
  localparam int AXI_ID_W   = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t AXI_OKAY = 2'b00;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    axi_resp_t               bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    axi_resp_t               rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

// File: rtl/boot_ctrl_pkg.sv
// Register map, CTRL bit positions, FSM states and STATUS layout of the boot sequencer.
package boot_ctrl_pkg;
  localparam logic [15:0] BOOT_ADDR_OFF = 16'h0000;
  localparam logic [15:0] CTRL_OFF      = 16'h0004;
  localparam logic [15:0] STATUS_OFF    = 16'h0008;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_HALT_BIT = 1;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } boot_st_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  restart_cnt;
    logic [4:0]  rsvd_lo;
    logic        halted;
    logic        busy;
    logic        running;
  } status_t;
endpackage

// File: rtl/boot_seq_ctrl_if.sv
// AXI request/response bundle between the interconnect and the boot sequencer CSR window.
interface boot_seq_ctrl_if;
  amba_axi_pkg::s_axi_mosi_t axi_mosi;
  amba_axi_pkg::s_axi_miso_t axi_miso;

  modport master (output axi_mosi, input axi_miso);
  modport slave  (input axi_mosi, output axi_miso);
endinterface

// File: rtl/boot_csr_axi.sv
// Single-outstanding AXI register front-end: turns AW/W into a write strobe and AR into a
// registered read of the offset presented on rd_off_o.
module boot_csr_axi
  import amba_axi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  boot_seq_ctrl_if.slave axi,
  output logic           wr_en_o,
  output logic [15:0]    wr_off_o,
  output logic [31:0]    wr_data_o,
  output logic [3:0]     wr_strb_o,
  output logic [15:0]    rd_off_o,
  input  logic [31:0]    rd_data_i
);
  logic        aw_pend_q, aw_pend_d;
  logic [7:0]  awid_q, awid_d;
  logic [15:0] awoff_q, awoff_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [7:0]  rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_fire, w_fire, b_fire, ar_fire, r_fire, wready;
  s_axi_miso_t miso;
  logic        unused_addr_hi;

  assign aw_fire = axi.axi_mosi.awvalid & ~aw_pend_q;
  // W may ride along with AW in the same cycle, so wready also opens on a live awvalid.
  assign wready  = ~bvalid_q & (aw_pend_q | axi.axi_mosi.awvalid);
  assign w_fire  = wready & axi.axi_mosi.wvalid;
  assign b_fire  = bvalid_q & axi.axi_mosi.bready;
  assign ar_fire = axi.axi_mosi.arvalid & ~rvalid_q;
  assign r_fire  = rvalid_q & axi.axi_mosi.rready;

  assign wr_en_o   = w_fire;
  assign wr_off_o  = aw_pend_q ? awoff_q : axi.axi_mosi.awaddr[15:0];
  assign wr_data_o = axi.axi_mosi.wdata;
  assign wr_strb_o = axi.axi_mosi.wstrb;
  assign rd_off_o  = axi.axi_mosi.araddr[15:0];

  assign unused_addr_hi = ^{axi.axi_mosi.awaddr[31:16], axi.axi_mosi.araddr[31:16]};

  always_comb begin
    aw_pend_d = aw_pend_q;
    awid_d    = awid_q;
    awoff_d   = awoff_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    if (aw_fire) begin
      aw_pend_d = 1'b1;
      awid_d    = axi.axi_mosi.awid;
      awoff_d   = axi.axi_mosi.awaddr[15:0];
    end else if (b_fire) begin
      aw_pend_d = 1'b0;
    end
    if (w_fire) begin
      bvalid_d = 1'b1;
    end else if (b_fire) begin
      bvalid_d = 1'b0;
    end
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rid_d    = axi.axi_mosi.arid;
      rdata_d  = rd_data_i;
    end else if (r_fire) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend_q <= 1'b0;
      awid_q    <= '0;
      awoff_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      aw_pend_q <= aw_pend_d;
      awid_q    <= awid_d;
      awoff_q   <= awoff_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    miso         = '0;
    miso.awready = ~aw_pend_q;
    miso.wready  = wready;
    miso.bid     = awid_q;
    miso.bresp   = AXI_OKAY;
    miso.bvalid  = bvalid_q;
    miso.arready = ~rvalid_q;
    miso.rid     = rid_q;
    miso.rdata   = rdata_q;
    miso.rresp   = AXI_OKAY;
    miso.rlast   = rvalid_q;
    miso.rvalid  = rvalid_q;
  end

  assign axi.axi_miso = miso;
endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the core in reset for a fixed time on every boot, then releases it
// with a boot vector latched at hold entry.
//   state  | meaning
//   HOLD   | core in reset, counter running, boot vector frozen
//   RUN    | core released; CTRL may restart (HOLD) or halt (HALTED)
//   HALTED | core in reset until software writes RUN
module boot_seq_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter logic [31:0] DEF_BOOT_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  boot_seq_ctrl_if.slave axi,
  output logic           cpu_rst_n_o,
  output logic [31:0]    boot_addr_o,
  output logic           busy_o
);
  localparam int unsigned CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);

  boot_st_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       restart_q, restart_d;
  logic [31:0]      boot_addr_q, boot_addr_d;
  logic [31:0]      boot_vec_q, boot_vec_d;

  logic        wr_en;
  logic [15:0] wr_off, rd_off;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic        ctrl_wr, run_req, halt_req;
  status_t     status;

  boot_csr_axi u_csr (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .wr_en_o   (wr_en),
    .wr_off_o  (wr_off),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .rd_off_o  (rd_off),
    .rd_data_i (rd_data)
  );

  assign ctrl_wr  = wr_en && (wr_off == CTRL_OFF);
  assign run_req  = ctrl_wr && wr_data[CTRL_RUN_BIT];
  assign halt_req = ctrl_wr && wr_data[CTRL_HALT_BIT];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    restart_d   = restart_q;
    boot_addr_d = boot_addr_q;
    boot_vec_d  = boot_vec_q;
    if (wr_en && (wr_off == BOOT_ADDR_OFF)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) boot_addr_d[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    case (state_q)
      HOLD: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (run_req) begin
          state_d   = HOLD;
          restart_d = restart_q + 8'd1;
        end
      end
      HALTED: begin
        if (run_req && !halt_req) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
    // The boot vector is only sampled here, so software edits in RUN stay invisible to the core.
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      cnt_d      = CNT_LOAD;
      boot_vec_d = boot_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= CNT_LOAD;
      restart_q   <= 8'd0;
      boot_addr_q <= DEF_BOOT_ADDR;
      boot_vec_q  <= DEF_BOOT_ADDR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      boot_addr_q <= boot_addr_d;
      boot_vec_q  <= boot_vec_d;
    end
  end

  always_comb begin
    status             = '0;
    status.running     = (state_q == RUN);
    status.busy        = (state_q == HOLD);
    status.halted      = (state_q == HALTED);
    status.restart_cnt = restart_q;
  end

  always_comb begin
    case (rd_off)
      BOOT_ADDR_OFF: rd_data = boot_addr_q;
      STATUS_OFF:    rd_data = status;
      default:       rd_data = 32'h0;
    endcase
  end

  assign cpu_rst_n_o = (state_q == RUN);
  assign busy_o      = (state_q == HOLD);
  assign boot_addr_o = boot_vec_q;
endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl: reset release, restart/halt sequencing, AXI handshakes.
module tb_boot_seq_ctrl;
  localparam int CLK_P = 10;

  logic        clk;
  logic        rst;
  logic        cpu_rst_n;
  logic [31:0] boot_addr;
  logic        busy;
  int          checks = 0;
  int          errors = 0;

  boot_seq_ctrl_if bus ();

  boot_seq_ctrl #(.RST_HOLD_CYCLES(16), .DEF_BOOT_ADDR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (bus),
    .cpu_rst_n_o (cpu_rst_n),
    .boot_addr_o (boot_addr),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #(CLK_P/2) clk = ~clk;

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] id, output logic [7:0] bid, output logic [1:0] bresp);
    int n;
    @(posedge clk); #1;
    bus.axi_mosi.awvalid = 1'b1;
    bus.axi_mosi.awaddr  = {16'h0, addr};
    bus.axi_mosi.awid    = id;
    bus.axi_mosi.wvalid  = 1'b1;
    bus.axi_mosi.wdata   = data;
    bus.axi_mosi.wstrb   = strb;
    n = 0;
    @(negedge clk);
    while (!(bus.axi_miso.awready && bus.axi_miso.wready) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.axi_mosi.awvalid = 1'b0;
    bus.axi_mosi.wvalid  = 1'b0;
    @(negedge clk);
    while (!bus.axi_miso.bvalid && n < 40) begin @(negedge clk); n++; end
    bid   = bus.axi_miso.bid;
    bresp = bus.axi_miso.bresp;
    if (n != 0) begin
      checks++; errors++;
      $display("FAIL axi_write_latency addr=%h extra_cycles=%0d required=0", addr, n);
    end
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [7:0] id,
                          output logic [31:0] data, output logic [7:0] rid, output logic rlast);
    int n;
    @(posedge clk); #1;
    bus.axi_mosi.arvalid = 1'b1;
    bus.axi_mosi.araddr  = {16'h0, addr};
    bus.axi_mosi.arid    = id;
    n = 0;
    @(negedge clk);
    while (!bus.axi_miso.arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.axi_mosi.arvalid = 1'b0;
    @(negedge clk);
    while (!bus.axi_miso.rvalid && n < 40) begin @(negedge clk); n++; end
    data  = bus.axi_miso.rdata;
    rid   = bus.axi_miso.rid;
    rlast = bus.axi_miso.rlast;
    if (n != 0) begin
      checks++; errors++;
      $display("FAIL axi_read_latency addr=%h extra_cycles=%0d required=0", addr, n);
    end
  endtask

  // Called at a negedge; returns the number of negedges seen with the core still in reset.
  task automatic wait_run(output int cyc);
    cyc = 0;
    while (cpu_rst_n == 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [7:0] id; logic l; int cyc;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (boot_addr !== 32'h0) begin errors++; $display("FAIL rst_boot_addr got=%h exp=0", boot_addr); end
    checks++; if (bus.axi_miso.awready !== 1'b1 || bus.axi_miso.arready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got aw=%b ar=%b exp 1/1", bus.axi_miso.awready, bus.axi_miso.arready); end
    checks++; if (bus.axi_miso.bvalid !== 1'b0 || bus.axi_miso.rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got b=%b r=%b exp 0/0", bus.axi_miso.bvalid, bus.axi_miso.rvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    wait_run(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL rst_hold_len got=%0d exp=16", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
    checks++; if (boot_addr !== 32'h0) begin errors++; $display("FAIL rst_boot_addr_run got=%h exp=0", boot_addr); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL rst_status got=%h exp=00000001", d); end
    axi_read(16'h4, 8'd2, d, id, l);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read got=%h exp=0", d); end
  endtask

  task automatic test_halt_resume();
    logic [31:0] d; logic [7:0] id; logic l; logic [1:0] r; int cyc;
    axi_write(16'h4, 32'h3, 4'hF, 8'd1, id, r);
    checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_outputs got rst_n=%b busy=%b exp 0/0", cpu_rst_n, busy); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL halt_status got=%h exp=00000004", d); end
    axi_write(16'h4, 32'h3, 4'hF, 8'd1, id, r);
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL halt_wins_halted got=%h exp=00000004", d); end
    axi_write(16'h4, 32'h1, 4'hF, 8'd1, id, r);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL resume_busy got=%b exp=1", busy); end
    wait_run(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL resume_hold_len got=%0d exp=16", cyc); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL resume_status got=%h exp=00000001", d); end
  endtask

  task automatic test_boot_vector();
    logic [31:0] d; logic [7:0] id; logic l; logic [1:0] r; int cyc;
    axi_write(16'h0, 32'h8000_0000, 4'hF, 8'd9, id, r);
    checks++; if (id !== 8'd9) begin errors++; $display("FAIL bv_bid got=%0d exp=9", id); end
    checks++; if (boot_addr !== 32'h0) begin errors++; $display("FAIL bv_stable got=%h exp=0", boot_addr); end
    axi_read(16'h0, 8'd1, d, id, l);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL bv_readback got=%h exp=80000000", d); end
    axi_write(16'h4, 32'h1, 4'hF, 8'd2, id, r);
    checks++; if (boot_addr !== 32'h8000_0000) begin errors++; $display("FAIL bv_latched got=%h exp=80000000", boot_addr); end
    wait_run(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL bv_hold_len got=%0d exp=16", cyc); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL bv_status got=%h exp=00000101", d); end
  endtask

  task automatic test_axi_split();
    logic [31:0] d; logic [7:0] id; logic l;
    @(posedge clk); #1;
    bus.axi_mosi.bready  = 1'b0;
    bus.axi_mosi.awvalid = 1'b1;
    bus.axi_mosi.awid    = 8'd3;
    bus.axi_mosi.awaddr  = 32'h0;
    @(negedge clk);
    checks++; if (bus.axi_miso.awready !== 1'b1) begin errors++; $display("FAIL split_aw_accept got=%b exp=1", bus.axi_miso.awready); end
    @(posedge clk); #1;
    bus.axi_mosi.awid   = 8'd7;
    bus.axi_mosi.awaddr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.axi_miso.wready !== 1'b1 || bus.axi_miso.bvalid !== 1'b0 || bus.axi_miso.awready !== 1'b0) begin
        errors++; $display("FAIL split_wait%0d got wready=%b bvalid=%b awready=%b exp 1/0/0", i,
                           bus.axi_miso.wready, bus.axi_miso.bvalid, bus.axi_miso.awready); end
    end
    @(posedge clk); #1;
    bus.axi_mosi.wvalid = 1'b1;
    bus.axi_mosi.wdata  = 32'hCAFE_0001;
    bus.axi_mosi.wstrb  = 4'hF;
    @(posedge clk); #1;
    bus.axi_mosi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.axi_miso.bvalid !== 1'b1 || bus.axi_miso.bid !== 8'd3 || bus.axi_miso.awready !== 1'b0) begin
        errors++; $display("FAIL split_bhold%0d got bvalid=%b bid=%0d awready=%b exp 1/3/0", i,
                           bus.axi_miso.bvalid, bus.axi_miso.bid, bus.axi_miso.awready); end
    end
    @(posedge clk); #1;
    bus.axi_mosi.bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.axi_miso.awready !== 1'b1 || bus.axi_miso.bvalid !== 1'b0) begin
      errors++; $display("FAIL split_after_b got awready=%b bvalid=%b exp 1/0", bus.axi_miso.awready, bus.axi_miso.bvalid); end
    @(posedge clk); #1;
    bus.axi_mosi.awvalid = 1'b0;
    bus.axi_mosi.wvalid  = 1'b1;
    bus.axi_mosi.wdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (bus.axi_miso.wready !== 1'b1) begin errors++; $display("FAIL split_w2_ready got=%b exp=1", bus.axi_miso.wready); end
    @(posedge clk); #1;
    bus.axi_mosi.wvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.axi_miso.bvalid !== 1'b1 || bus.axi_miso.bid !== 8'd7) begin
      errors++; $display("FAIL split_b2 got bvalid=%b bid=%0d exp 1/7", bus.axi_miso.bvalid, bus.axi_miso.bid); end
    axi_read(16'h0, 8'd5, d, id, l);
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL split_rdata got=%h exp=cafe0001", d); end
    checks++; if (id !== 8'd5 || l !== 1'b1) begin errors++; $display("FAIL split_rid got rid=%0d rlast=%b exp 5/1", id, l); end
    checks++; if (cpu_rst_n !== 1'b1 || boot_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL split_state got rst_n=%b boot=%h exp 1/80000000", cpu_rst_n, boot_addr); end
  endtask

  task automatic test_edge_cases();
    logic [31:0] d; logic [7:0] id; logic l; logic [1:0] r; int cyc; time t0;
    axi_write(16'h4, 32'h1, 4'hF, 8'd1, id, r);
    t0 = $time;
    checks++; if (boot_addr !== 32'hCAFE_0001) begin errors++; $display("FAIL edge_bv_entry got=%h exp=cafe0001", boot_addr); end
    axi_write(16'h4, 32'h1, 4'hF, 8'd1, id, r);
    wait_run(cyc);
    cyc = int'(($time - t0) / CLK_P);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL edge_hold_not_extended got=%0d exp=16", cyc); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL edge_hold_ignored got=%h exp=00000201", d); end
    axi_write(16'h10, 32'hFFFF_FFFF, 4'hF, 8'd4, id, r);
    checks++; if (r !== 2'b00 || id !== 8'd4) begin errors++; $display("FAIL edge_unmapped_resp got bresp=%b bid=%0d exp 00/4", r, id); end
    checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL edge_unmapped_state got=%b exp=1", cpu_rst_n); end
    axi_read(16'h10, 8'd1, d, id, l);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_unmapped_read got=%h exp=0", d); end
    axi_write(16'h0, 32'h1122_3344, 4'b0001, 8'd1, id, r);
    axi_read(16'h0, 8'd1, d, id, l);
    checks++; if (d !== 32'hCAFE_0044) begin errors++; $display("FAIL edge_wstrb got=%h exp=cafe0044", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic [7:0] id; logic l; logic [1:0] r; int cyc;
    for (int i = 0; i < 253; i++) begin
      axi_write(16'h4, 32'h1, 4'hF, 8'd1, id, r);
      wait_run(cyc);
    end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_FF01) begin errors++; $display("FAIL wrap_255 got=%h exp=0000ff01", d); end
    axi_write(16'h4, 32'h1, 4'hF, 8'd1, id, r);
    wait_run(cyc);
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL wrap_0 got=%h exp=00000001", d); end
  endtask

  task automatic test_midop_reset();
    logic [31:0] d; logic [7:0] id; logic l; int cyc;
    @(posedge clk); #1;
    bus.axi_mosi.rready  = 1'b0;
    bus.axi_mosi.arvalid = 1'b1;
    bus.axi_mosi.araddr  = 32'h8;
    bus.axi_mosi.awvalid = 1'b1;
    bus.axi_mosi.awaddr  = 32'h0;
    @(posedge clk); #1;
    bus.axi_mosi.arvalid = 1'b0;
    bus.axi_mosi.awvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.axi_miso.rvalid !== 1'b1 || bus.axi_miso.awready !== 1'b0) begin
      errors++; $display("FAIL mid_pending got rvalid=%b awready=%b exp 1/0", bus.axi_miso.rvalid, bus.axi_miso.awready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.axi_miso.rvalid !== 1'b0 || bus.axi_miso.bvalid !== 1'b0 ||
                  bus.axi_miso.awready !== 1'b1 || bus.axi_miso.arready !== 1'b1) begin
      errors++; $display("FAIL mid_axi_drop got rvalid=%b bvalid=%b awready=%b arready=%b exp 0/0/1/1",
                         bus.axi_miso.rvalid, bus.axi_miso.bvalid, bus.axi_miso.awready, bus.axi_miso.arready); end
    checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b1 || boot_addr !== 32'h0) begin
      errors++; $display("FAIL mid_fsm got rst_n=%b busy=%b boot=%h exp 0/1/0", cpu_rst_n, busy, boot_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.axi_mosi.rready = 1'b1;
    @(negedge clk);
    wait_run(cyc);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL mid_hold_len got=%0d exp=16", cyc); end
    axi_read(16'h8, 8'd1, d, id, l);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL mid_status got=%h exp=00000001", d); end
    axi_read(16'h0, 8'd1, d, id, l);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_boot_addr_reg got=%h exp=0", d); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.axi_mosi     = '0;
    bus.axi_mosi.bready = 1'b1;
    bus.axi_mosi.rready = 1'b1;
    test_reset();
    test_halt_resume();
    test_boot_vector();
    test_axi_split();
    test_edge_cases();
    test_wrap();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/boot_seq_ctrl.md
# boot_seq_ctrl

Boot sequencer for the NOX SoC: owns the core's boot (reset) vector register and sequences the core's local reset around it. It exposes a small AXI CSR window, holds the core in reset for a fixed number of cycles after system reset or a software restart, and then releases it. While the core runs, it presents a boot address that stays stable. It sits on the AXI interconnect beside the other peripherals and drives the core's reset and boot-address inputs.

## Interface
- `RST_HOLD_CYCLES`, default 16: cycles the core reset is held on each boot, must be at least 1.
- `DEF_BOOT_ADDR`, default 32'h0000_0000: reset value of the BOOT_ADDR register.
- `clk`  in  1  single clock domain; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `axi_mosi`  in  s_axi_mosi_t  AXI requests from the interconnect.
- `axi_miso`  out  s_axi_miso_t  AXI responses.
- `cpu_rst_n_o`  out  1  core reset, active-low. It is 0 while the core is held in reset.
- `boot_addr_o`  out  32  boot vector latched at entry to HOLD.
- `busy_o`  out  1  high when the FSM is in HOLD.

## Operation
- Registers are decoded on `axaddr[15:0]`:
  - 0x0 BOOT_ADDR: read/write, 32 bits.
  - 0x4 CTRL: write-only. bit0 RUN requests a start or restart; bit1 HALT. Reads return 0.
  - 0x8 STATUS: read-only. bit0 running, bit1 busy, bit2 halted, [15:8] restart_cnt.
  - Any other offset: writes are ignored and reads return 0. The response is always OKAY.
- FSM states:
  - **HOLD**: `cpu_rst_n_o`=0, `busy_o`=1. A down-counter is loaded with RST_HOLD_CYCLES-1 on entry. When the counter reaches 0, go to RUN.
  - **RUN**: `cpu_rst_n_o`=1.
    - CTRL write with RUN=1 → HOLD, and restart_cnt increments (8-bit, wraps 255→0).
    - CTRL write with HALT=1 → HALTED.
  - **HALTED**: `cpu_rst_n_o`=0. A CTRL write with RUN=1 → HOLD. restart_cnt does not increment on this path.
- RUN and HALT set in the same CTRL write: HALT wins in every state.
- CTRL writes received in HOLD are ignored. An in-progress hold is never extended or aborted by software.
- On entry to HOLD, `boot_addr_o` is loaded from BOOT_ADDR. This includes the cycle after reset, when it takes `DEF_BOOT_ADDR`. Writes to BOOT_ADDR while in RUN do not affect `boot_addr_o` until the next HOLD entry.
- AXI write path:
  - One transaction is outstanding at a time. `awready` is 1 while no write is pending. `wready` is 1 once AW has been captured.
  - AW and W may arrive in the same cycle, or W may arrive later. Until W arrives, `wready` stays 1 and `bvalid` stays 0.
  - On the W handshake: perform the register write, then raise `bvalid` the next cycle with `bid` equal to the captured `awid`. `bvalid` is held until `bready`.
  - `awready` returns to 1 in the cycle after the B handshake.
  - `wstrb` is honoured per byte for BOOT_ADDR only.
- AXI read path:
  - `arready` is 1 while no read is pending.
  - `rvalid`=1 and `rlast`=1 in the cycle after the AR handshake, with `rid` equal to the captured `arid`. Data is held until `rready`.
  - Read data is sampled at the AR handshake. A read and a write to the same register in the same cycle therefore return the old value.

## Timing
- While `rst` is high, at every edge:
  - the FSM is in HOLD with the counter at RST_HOLD_CYCLES-1;
  - `cpu_rst_n_o`=0, `busy_o`=1, `boot_addr_o`=`DEF_BOOT_ADDR`, restart_cnt=0;
  - all AXI valid outputs are 0, with `awready`=1 and `arready`=1.
- After `rst` deasserts, `cpu_rst_n_o` rises exactly RST_HOLD_CYCLES cycles after the first edge with `rst`=0.
- CTRL write effect: the FSM changes state on the edge of the W handshake. `cpu_rst_n_o` falls in the following cycle, together with `bvalid`.
- Reset asserted mid-operation: all in-flight AXI transactions are dropped with no response, and the FSM returns to HOLD.
- Write latency is W handshake +1 cycle to `bvalid`. Read latency is AR handshake +1 cycle to `rvalid`.

## Structure
- `boot_ctrl_pkg` holds:
  - the register offset localparams (`BOOT_ADDR_OFF`, `CTRL_OFF`, `STATUS_OFF`);
  - the CTRL bit positions;
  - the `boot_st_t` enum (HOLD, RUN, HALTED);
  - the STATUS field packing typedef.
- The AXI types come from `amba_axi_pkg`.
- One sub-module, `boot_csr_axi`: the AXI single-beat register front-end. It issues a write strobe with offset, data and strb, and a read request with offset, taking read data back. `boot_seq_ctrl` contains the FSM, counter and registers.

## Test plan
- **Reset release**: `rst`=1 for 5 cycles, then 0 → `cpu_rst_n_o` is 0 for exactly 16 cycles, then 1; `boot_addr_o`=0x0; STATUS reads 0x0000_0001.
- **Boot vector update**: write BOOT_ADDR=0x8000_0000 while in RUN → `boot_addr_o` stays 0x0. Then write CTRL=0x1 → `cpu_rst_n_o`=0 for 16 cycles, `boot_addr_o`=0x8000_0000, STATUS[15:8]=1.
- **Halt and resume**: write CTRL=0x3 → HALTED (HALT wins) and STATUS=0x0000_0004. Then write CTRL=0x1 → HOLD, then RUN; restart_cnt is unchanged.
- **AXI split and backpressure**: send AW with `awid`=3, delay W by 4 cycles, hold `bready`=0 for 3 cycles → `wready` stays 1 while waiting, `bvalid` is held, `bid`=3, and no second AW is accepted until B completes. Read of 0x0 with `arid`=5 returns `rid`=5, `rlast`=1.
- **Edge cases**:
  - write CTRL=0x1 during HOLD → ignored, and the hold length is still 16;
  - write to offset 0x10 → OKAY, no state change;
  - `wstrb`=4'b0001 on BOOT_ADDR → only byte 0 is updated;
  - 256 restarts → restart_cnt wraps to 0.
